large_mul_sched: RTL
====================

# large_mul_sched

Scheduler that computes a full 1024×1024-bit product by time-sharing one external 1024×256 serial shift-add multiplier core. Operand B is split into four 256-bit slices. Each slice is launched on the core in turn, and each returned 1280-bit partial product is accumulated at offset 256·i into a 2048-bit result. The block sits between the large-multiplication front end (valid/ready operand source) and the multiplier core.

## Interface
- SLICE_W, 256, multiplier-core slice width; NSLICE = 1024/SLICE_W (only the default is supported)
- TIMEOUT, 600, maximum cycles in WAIT before flagging an error
- clk  in  1  clock; all logic on the rising edge
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept; high only in IDLE
- in_a  in  1024  multiplicand
- in_b  in  1024  multiplier
- out_valid  out  1  result available; held until taken
- out_ready  in  1  consumer accepts result
- out_p  out  2048  product in_a × in_b
- out_err  out  1  core timeout occurred; out_p is invalid; qualified by out_valid
- busy  out  1  high in every state except IDLE
- mul_in1  out  1024  to core; equals the latched A
- mul_in2  out  256  to core; current B slice
- mul_start  out  1  one-cycle launch pulse
- mul_done  in  1  one-cycle pulse from the core; mul_out valid in the same cycle
- mul_out  in  1280  core partial product

## Operation
- States: IDLE, LAUNCH, WAIT, ACCUM, DONE, ERR.
- IDLE:
  - On in_valid&&in_ready: latch A and B, clear acc (2048 bits), set slice index i=0, go to LAUNCH.
- LAUNCH:
  - Drive mul_in2 = B[256i+255:256i] and pulse mul_start=1.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - mul_start=0; mul_in1 and mul_in2 are held stable.
  - On mul_done, capture mul_out and go to ACCUM.
  - If the counter reaches TIMEOUT first, go to ERR.
- ACCUM:
  - Compute {carry, acc[256i+1279:256i]} = acc[256i+1279:256i] + mul_out as a 1281-bit add.
  - For i<3, write carry into bit 256i+1280. For i=3 the carry is provably 0 and is discarded.
  - If i==3, go to DONE. Otherwise increment i and go to LAUNCH.
- DONE:
  - out_valid=1, out_p=acc, out_err=0.
  - On out_ready, return to IDLE.
- ERR:
  - out_valid=1, out_err=1, out_p=0.
  - On out_ready, return to IDLE.
- mul_done outside WAIT is ignored.
- Reset mid-operation:
  - Next state IDLE; acc, A, B, i and the counter are cleared; all outputs return to reset values.
  - A core completion still in flight is ignored.
- Reset values: in_ready=1, out_valid=0, out_err=0, out_p=0, busy=0, mul_start=0, mul_in1=0, mul_in2=0.

## Timing
- Accept cycle = 0. LAUNCH for slice i occurs at cycle 1+i·(Lm+2), where Lm is the number of cycles from mul_start to mul_done.
- ACCUM for slice i occurs at LAUNCH+Lm+1. out_valid first rises at cycle 4·Lm+9.
- in_ready falls the cycle after acceptance and rises the cycle after out_valid&&out_ready.
- There is no back-to-back overlap: the next accept occurs no earlier than that cycle.
- Timeout: ERR is entered when WAIT has lasted TIMEOUT cycles without mul_done. ERR out_valid rises the following cycle.
- out_valid does not drop without out_ready. out_p and out_err are stable while out_valid=1.

## Configuration
- SKIP_ZERO_SLICE_EN:
  - Defined: in LAUNCH, if the current B slice is 0, do not pulse mul_start and leave acc unchanged. In that case, if i==3 go to DONE, otherwise increment i and go to LAUNCH (1 cycle per skipped slice). If B==0 entirely, out_valid rises at cycle 5.
  - Undefined: every slice is launched regardless of value, and latency is always 4·Lm+9.

## Structure
- Package large_mul_pkg holds:
  - widths A_W=1024, SLICE_W=256, ACC_W=2048, PP_W=1280, NSLICE=4
  - the state enum
  - the default TIMEOUT
- One sub-module, large_mul_slice_acc: the 1281-bit windowed add into the 2048-bit accumulator at offset 256·i. It is combinational, registered by the parent.
- FSM, counters and handshakes live in large_mul_sched.

## Test plan
- Core model with Lm=258, in_a=2^1024−1, in_b=2^1024−1: out_p = 2^2048 − 2^1025 + 1, out_err=0, out_valid at cycle 1041.
- in_a=3, in_b=(1<<768)|(1<<256)|5: out_p = 3·in_b. Check one mul_start per slice (4 total, macro undefined).
- With SKIP_ZERO_SLICE_EN and in_b=1<<512: exactly 1 mul_start; out_p = in_a<<512; out_valid at cycle 3+(Lm+2)+1.
- Core model never asserts mul_done: ERR after TIMEOUT=600 WAIT cycles; out_valid=1, out_err=1, out_p=0. With out_ready=1, the block returns to IDLE with in_ready=1.
- out_ready held 0 for 20 cycles after DONE: out_valid and out_p stable, in_valid ignored (in_ready=0). Then out_ready=1 accepts, and a new operand is accepted on the following cycle.
- rstn=0 for one cycle during WAIT of slice 2, with a stale mul_done arriving 5 cycles later: all outputs at reset values, the stale mul_done ignored, and a fresh operation with in_a=7, in_b=9 returns 63.

Source files
------------

// File: rtl/large_mul_sched_pkg.sv
// large_mul_pkg: widths, FSM states and defaults shared by the large multiplier scheduler.
package large_mul_pkg;
  localparam int A_W = 1024;
  localparam int SLICE_W = 256;
  localparam int ACC_W = 2048;
  localparam int PP_W = 1280;
  localparam int NSLICE = 4;
  localparam int DEF_TIMEOUT = 600;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ACCUM, DONE, ERR} state_t;
  function automatic logic [SLICE_W-1:0] slice_of(input logic [A_W-1:0] b, input logic [1:0] i);
    return SLICE_W'(b >> {i, 8'd0});
  endfunction
endpackage

// File: rtl/large_mul_sched_if.sv
// large_mul_sched_if: operand/result handshake plus multiplier-core port of the scheduler.
interface large_mul_sched_if;
  import large_mul_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, out_err, busy, mul_start, mul_done;
  logic [A_W-1:0] in_a, in_b, mul_in1;
  logic [ACC_W-1:0] out_p;
  logic [SLICE_W-1:0] mul_in2;
  logic [PP_W-1:0] mul_out;
  modport slave (
    input in_valid, in_a, in_b, out_ready, mul_done, mul_out,
    output in_ready, out_valid, out_p, out_err, busy, mul_in1, mul_in2, mul_start
  );
  modport master (
    output in_valid, in_a, in_b, out_ready, mul_done, mul_out,
    input in_ready, out_valid, out_p, out_err, busy, mul_in1, mul_in2, mul_start
  );
endinterface

// File: rtl/large_mul_sched_slice_acc.sv
// large_mul_slice_acc: adds a partial product into the accumulator window at offset 256*idx.
module large_mul_slice_acc
  import large_mul_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [PP_W-1:0]  pp,
  input  logic [1:0]       idx,
  output logic [ACC_W-1:0] acc_next
);
  logic [11:0] base;
  logic [PP_W:0] sum;
  logic [ACC_W:0] ext;
  // One spare bit above the accumulator absorbs the last slice's carry, which is always 0.
  always_comb begin
    base = {2'b0, idx, 8'd0};
    ext = {1'b0, acc};
    sum = {1'b0, ext[base +: PP_W]} + {1'b0, pp};
    ext[base +: PP_W+1] = sum;
    acc_next = ext[ACC_W-1:0];
  end
endmodule

// File: rtl/large_mul_sched.sv
// large_mul_sched: 1024x1024 product via four launches of a 1024x256 serial multiplier core.
// Define SKIP_ZERO_SLICE_EN to skip launching the core for all-zero B slices.
module large_mul_sched
  import large_mul_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clk,
  input logic rstn,
  large_mul_sched_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
`ifdef SKIP_ZERO_SLICE_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  state_t state;
  logic [A_W-1:0] a, b;
  logic [ACC_W-1:0] acc, acc_next;
  logic [PP_W-1:0] pp;
  logic [1:0] idx, nidx;
  logic [CW-1:0] cnt;
  logic [SLICE_W-1:0] first_slice, next_slice;
  assign nidx = idx + 2'd1;
  assign first_slice = slice_of(bus.in_b, 2'd0);
  assign next_slice = slice_of(b, nidx);
  assign bus.mul_in1 = a;
  large_mul_slice_acc u_acc (.acc(acc), .pp(pp), .idx(idx), .acc_next(acc_next));
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      acc <= '0;
      pp <= '0;
      idx <= '0;
      cnt <= '0;
      bus.in_ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_err <= 1'b0;
      bus.out_p <= '0;
      bus.mul_in2 <= '0;
      bus.mul_start <= 1'b0;
    end else begin
      bus.mul_start <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          a <= bus.in_a;
          b <= bus.in_b;
          acc <= '0;
          idx <= '0;
          bus.in_ready <= 1'b0;
          bus.busy <= 1'b1;
          bus.mul_in2 <= first_slice;
          bus.mul_start <= !SKIP || |first_slice;
          state <= LAUNCH;
        end
        LAUNCH: begin
          cnt <= '0;
          if (SKIP && bus.mul_in2 == '0) begin
            if (idx == 2'd3) begin
              bus.out_valid <= 1'b1;
              bus.out_p <= acc;
              state <= DONE;
            end else begin
              idx <= nidx;
              bus.mul_in2 <= next_slice;
              bus.mul_start <= !SKIP || |next_slice;
            end
          end else state <= WAIT;
        end
        WAIT: if (bus.mul_done) begin
          pp <= bus.mul_out;
          state <= ACCUM;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          bus.out_valid <= 1'b1;
          bus.out_err <= 1'b1;
          bus.out_p <= '0;
          state <= ERR;
        end else cnt <= cnt + 1'b1;
        ACCUM: begin
          acc <= acc_next;
          if (idx == 2'd3) begin
            bus.out_valid <= 1'b1;
            bus.out_p <= acc_next;
            state <= DONE;
          end else begin
            idx <= nidx;
            bus.mul_in2 <= next_slice;
            bus.mul_start <= !SKIP || |next_slice;
            state <= LAUNCH;
          end
        end
        DONE, ERR: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.out_err <= 1'b0;
          bus.out_p <= '0;
          bus.in_ready <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
